// File: rtl/instruction_sequencer.sv
// Program sequencer: fetches words from synchronous instruction memory, issues them to the cpu,
// stalls on tensor operate words and halts on 16'hFFFF. Optional single-step: SEQUENCER_SINGLE_STEP_EN.
module instruction_sequencer #(
    parameter int unsigned PROGRAM_DEPTH  = 1024,
    parameter int unsigned TENSOR_TIMEOUT = 255,
    parameter logic [15:0] NOP_WORD       = 16'h9000,
    localparam int unsigned AW            = $clog2(PROGRAM_DEPTH)
) (
    input  logic          clock_in,
    input  logic          reset_n_in,
    input  logic          start_in,
`ifdef SEQUENCER_SINGLE_STEP_EN
    input  logic          step_mode_in,
    input  logic          step_in,
`endif
    output logic          imem_read_enable_out,
    output logic [AW-1:0] imem_address_out,
    input  logic [15:0]   imem_data_in,
    input  logic          tensor_core_done_in,
    output logic [15:0]   current_instruction_out,
    output logic          instruction_valid_out,
    output logic [AW-1:0] program_counter_out,
    output logic          busy_out,
    output logic          halted_out,
    output logic          fault_out,
    output logic [15:0]   issue_count_out
);

    localparam int unsigned TMO_W   = $clog2(TENSOR_TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_PC = AW'(PROGRAM_DEPTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TENSOR_TIMEOUT - 1);
    localparam logic [15:0] SENTINEL = 16'hFFFF;
    localparam logic [3:0]  OP_TENSOR = 4'b0101;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;
`ifdef SEQUENCER_SINGLE_STEP_EN
    localparam logic [2:0] ST_STEP   = 3'd5;
`endif

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [15:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             rd_en_q, rd_en_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             fault_q, fault_d;
    logic [15:0]      count_q, count_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [2:0]       resume_st_c;

    // Where the sequencer goes whenever it is ready for the next fetch
`ifdef SEQUENCER_SINGLE_STEP_EN
    assign resume_st_c = step_mode_in ? ST_STEP : ST_FETCH;
`else
    assign resume_st_c = ST_FETCH;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = NOP_WORD;
        valid_d  = 1'b0;
        fault_d  = fault_q;
        count_d  = count_q;
        tmo_d    = tmo_q;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start_in) begin
                    state_d = resume_st_c;
                    pc_d    = '0;
                    fault_d = 1'b0;
                    count_d = '0;
                end
            end
            ST_FETCH: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (imem_data_in == SENTINEL) begin
                    state_d = ST_HALTED;
                end else begin
                    instr_d = imem_data_in;
                    valid_d = 1'b1;
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    // Last address issued: stop without wrapping the PC
                    if (pc_q == LAST_PC) begin
                        state_d = ST_HALTED;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = pc_q + AW'(1);
                        if (imem_data_in[15:12] == OP_TENSOR) begin
                            state_d = ST_WAIT;
                            tmo_d   = '0;
                        end else begin
                            state_d = resume_st_c;
                        end
                    end
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                // First wait cycle is the operate issue cycle; a stale done is ignored there
                if ((tmo_q != '0) && tensor_core_done_in) begin
                    state_d = resume_st_c;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_HALTED;
                    fault_d = 1'b1;
                end
            end
`ifdef SEQUENCER_SINGLE_STEP_EN
            ST_STEP: begin
                if (step_in) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_en_d  = (state_d == ST_FETCH);
        halted_d = (state_d == ST_HALTED);
        busy_d   = (state_d != ST_IDLE) && (state_d != ST_HALTED);
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            count_q  <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            rd_en_q  <= rd_en_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            count_q  <= count_d;
            tmo_q    <= tmo_d;
        end
    end

    assign imem_read_enable_out    = rd_en_q;
    assign imem_address_out        = pc_q;
    assign current_instruction_out = instr_q;
    assign instruction_valid_out   = valid_q;
    assign program_counter_out     = pc_q;
    assign busy_out                = busy_q;
    assign halted_out              = halted_q;
    assign fault_out               = fault_q;
    assign issue_count_out         = count_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: two instances (small depth/timeout and a larger
// one for the long tensor stall), synchronous memory models and an issued-word scoreboard.
module tb_instruction_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_a, start_b, done_a, done_b;

    logic        rd_a, valid_a, busy_a, halted_a, fault_a;
    logic [1:0]  addr_a, pc_a;
    logic [15:0] rdata_a, instr_a, count_a;

    logic        rd_b, valid_b, busy_b, halted_b, fault_b;
    logic [3:0]  addr_b, pc_b;
    logic [15:0] rdata_b, instr_b, count_b;

    logic [15:0] mem_a [4];
    logic [15:0] mem_b [16];
    logic [15:0] exp_a [$];
    logic [15:0] exp_b [$];

    int n_checks = 0;
    int n_fail   = 0;

    instruction_sequencer #(.PROGRAM_DEPTH(4), .TENSOR_TIMEOUT(8), .NOP_WORD(16'h9000)) u_dut_a (
        .clock_in(clk), .reset_n_in(rst_n), .start_in(start_a),
        .imem_read_enable_out(rd_a), .imem_address_out(addr_a), .imem_data_in(rdata_a),
        .tensor_core_done_in(done_a), .current_instruction_out(instr_a),
        .instruction_valid_out(valid_a), .program_counter_out(pc_a), .busy_out(busy_a),
        .halted_out(halted_a), .fault_out(fault_a), .issue_count_out(count_a)
    );

    instruction_sequencer #(.PROGRAM_DEPTH(16), .TENSOR_TIMEOUT(255), .NOP_WORD(16'h9000)) u_dut_b (
        .clock_in(clk), .reset_n_in(rst_n), .start_in(start_b),
        .imem_read_enable_out(rd_b), .imem_address_out(addr_b), .imem_data_in(rdata_b),
        .tensor_core_done_in(done_b), .current_instruction_out(instr_b),
        .instruction_valid_out(valid_b), .program_counter_out(pc_b), .busy_out(busy_b),
        .halted_out(halted_b), .fault_out(fault_b), .issue_count_out(count_b)
    );

    // Synchronous-read program memories
    always @(posedge clk) if (rd_a) rdata_a <= mem_a[addr_a];
    always @(posedge clk) if (rd_b) rdata_b <= mem_b[addr_b];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every valid pulse must match the next expected word
    always @(negedge clk) begin
        logic [15:0] w;
        if (valid_a) begin
            if (exp_a.size() == 0) check("a_unexpected_issue", 32'(exp_a.size()), 32'd1);
            else begin
                w = exp_a.pop_front();
                check("a_issue_word", 32'(instr_a), 32'(w));
            end
        end
        if (valid_b) begin
            if (exp_b.size() == 0) check("b_unexpected_issue", 32'(exp_b.size()), 32'd1);
            else begin
                w = exp_b.pop_front();
                check("b_issue_word", 32'(instr_b), 32'(w));
            end
        end
    end

    task automatic load_a(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3);
        mem_a[0] = w0; mem_a[1] = w1; mem_a[2] = w2; mem_a[3] = w3;
    endtask

    task automatic start_dut_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; done_a = 1'b0; done_b = 1'b0;
        for (int i = 0; i < 16; i++) mem_b[i] = 16'h0000;
        load_a(16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // Reset values
        repeat (3) tick();
        check("rst_instr", 32'(instr_a), 32'h9000);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_pc", 32'(pc_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_halted", 32'(halted_a), 32'd0);
        check("rst_fault", 32'(fault_a), 32'd0);
        check("rst_count", 32'(count_a), 32'd0);
        check("rst_rd", 32'(rd_a), 32'd0);
        check("rst_b_instr", 32'(instr_b), 32'h9000);
        check("rst_b_pc", 32'(pc_b), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic program
        load_a(16'hA105, 16'h0012, 16'hFFFF, 16'h0000);
        exp_a.push_back(16'hA105); exp_a.push_back(16'h0012);
        start_dut_a();                                  // cycle 1
        check("basic_c1_rd", 32'(rd_a), 32'd1);
        check("basic_c1_addr", 32'(addr_a), 32'd0);
        check("basic_c1_busy", 32'(busy_a), 32'd1);
        repeat (2) tick();                              // cycle 3
        check("basic_c3_valid", 32'(valid_a), 32'd1);
        check("basic_c3_instr", 32'(instr_a), 32'hA105);
        tick();                                         // cycle 4
        check("basic_c4_nop", 32'(instr_a), 32'h9000);
        check("basic_c4_valid", 32'(valid_a), 32'd0);
        tick();                                         // cycle 5
        check("basic_c5_valid", 32'(valid_a), 32'd1);
        check("basic_c5_instr", 32'(instr_a), 32'h0012);
        tick();                                         // cycle 6
        check("basic_c6_halted", 32'(halted_a), 32'd0);
        tick();                                         // cycle 7
        check("basic_c7_halted", 32'(halted_a), 32'd1);
        check("basic_c7_busy", 32'(busy_a), 32'd0);
        check("basic_c7_valid", 32'(valid_a), 32'd0);
        check("basic_count", 32'(count_a), 32'd2);
        check("basic_fault", 32'(fault_a), 32'd0);
        check("basic_sb_empty", 32'(exp_a.size()), 32'd0);

        // Tensor timeout (8 wait cycles), then restart clears the fault
        load_a(16'h5000, 16'h0000, 16'hFFFF, 16'h0000);
        exp_a.push_back(16'h5000);
        done_a = 1'b0;
        start_dut_a();                                  // cycle 1
        repeat (2) tick();                              // cycle 3, first wait cycle
        check("tmo_c3_instr", 32'(instr_a), 32'h5000);
        repeat (7) tick();                              // cycle 10, eighth wait cycle
        check("tmo_c10_busy", 32'(busy_a), 32'd1);
        check("tmo_c10_halted", 32'(halted_a), 32'd0);
        tick();                                         // cycle 11
        check("tmo_halted", 32'(halted_a), 32'd1);
        check("tmo_fault", 32'(fault_a), 32'd1);
        check("tmo_count", 32'(count_a), 32'd1);
        load_a(16'hA105, 16'h0012, 16'hFFFF, 16'h0000);
        exp_a.push_back(16'hA105); exp_a.push_back(16'h0012);
        start_dut_a();
        check("restart_fault_clr", 32'(fault_a), 32'd0);
        check("restart_addr", 32'(addr_a), 32'd0);
        check("restart_rd", 32'(rd_a), 32'd1);
        check("restart_count_clr", 32'(count_a), 32'd0);
        repeat (6) tick();                              // cycle 7
        check("restart_halted", 32'(halted_a), 32'd1);
        check("restart_count", 32'(count_a), 32'd2);
        check("restart_fault", 32'(fault_a), 32'd0);

        // Run off the end of a 4-word memory
        load_a(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        for (int i = 1; i <= 4; i++) exp_a.push_back(16'(i));
        start_dut_a();                                  // cycle 1
        repeat (8) tick();                              // cycle 9
        check("runoff_valid", 32'(valid_a), 32'd1);
        check("runoff_instr", 32'(instr_a), 32'h0004);
        check("runoff_halted", 32'(halted_a), 32'd1);
        check("runoff_fault", 32'(fault_a), 32'd1);
        check("runoff_count", 32'(count_a), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("runoff_pc_hold", 32'(pc_a), 32'd3);
            check("runoff_no_fetch", 32'(rd_a), 32'd0);
            tick();
        end
        check("runoff_sb_empty", 32'(exp_a.size()), 32'd0);

        // Start during FETCH is ignored; reset mid-WAIT_TENSOR
        load_a(16'h0001, 16'h5000, 16'h0000, 16'hFFFF);
        exp_a.push_back(16'h0001); exp_a.push_back(16'h5000);
        done_a = 1'b0;
        start_dut_a();                                  // cycle 1
        repeat (2) tick();                              // cycle 3, FETCH of address 1
        check("busy_fetch_rd", 32'(rd_a), 32'd1);
        start_a = 1'b1;
        tick();                                         // cycle 4
        start_a = 1'b0;
        check("busy_start_pc", 32'(pc_a), 32'd1);
        check("busy_start_rd", 32'(rd_a), 32'd0);
        check("busy_start_count", 32'(count_a), 32'd1);
        tick();                                         // cycle 5
        check("wait_issue_instr", 32'(instr_a), 32'h5000);
        check("wait_issue_pc", 32'(pc_a), 32'd2);
        tick();                                         // cycle 6, waiting
        check("wait_busy", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_instr", 32'(instr_a), 32'h9000);
        check("midrst_valid", 32'(valid_a), 32'd0);
        check("midrst_pc", 32'(pc_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_halted", 32'(halted_a), 32'd0);
        check("midrst_fault", 32'(fault_a), 32'd0);
        check("midrst_count", 32'(count_a), 32'd0);
        check("midrst_rd", 32'(rd_a), 32'd0);
        rst_n = 1'b1;
        tick();
        check("midrst_sb_empty", 32'(exp_a.size()), 32'd0);

        // Tensor stall on the large instance: stale done ignored, 10 low cycles, then resume
        mem_b[0] = 16'h5000; mem_b[1] = 16'h0000; mem_b[2] = 16'hFFFF;
        exp_b.push_back(16'h5000); exp_b.push_back(16'h0000);
        done_b = 1'b1;
        start_b = 1'b1;
        tick();                                         // cycle 1
        start_b = 1'b0;
        repeat (2) tick();                              // cycle 3, first wait cycle, done high
        check("stall_c3_instr", 32'(instr_b), 32'h5000);
        tick();                                         // cycle 4
        done_b = 1'b0;
        for (int i = 0; i < 10; i++) begin              // cycles 4..13
            check("stall_no_fetch", 32'(rd_b), 32'd0);
            check("stall_busy", 32'(busy_b), 32'd1);
            tick();
        end
        done_b = 1'b1;                                  // cycle 14
        check("stall_c14_no_fetch", 32'(rd_b), 32'd0);
        tick();                                         // cycle 15
        done_b = 1'b0;
        check("stall_resume_rd", 32'(rd_b), 32'd1);
        check("stall_resume_addr", 32'(addr_b), 32'd1);
        repeat (2) tick();                              // cycle 17
        check("stall_c17_instr", 32'(instr_b), 32'h0000);
        check("stall_c17_valid", 32'(valid_b), 32'd1);
        repeat (3) tick();                              // cycle 20
        check("stall_halted", 32'(halted_b), 32'd1);
        check("stall_count", 32'(count_b), 32'd2);
        check("stall_fault", 32'(fault_b), 32'd0);
        check("stall_pc", 32'(pc_b), 32'd2);
        check("stall_sb_empty", 32'(exp_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Program sequencer that fetches 16-bit machine-code words from a synchronous-read instruction memory and issues them to the cpu's `current_instruction` input. It stalls after each tensor-core operate instruction until the tensor core reports completion. It halts on the 16'hFFFF end-of-program sentinel. It replaces bench-driven instruction stepping with an on-chip controller sitting between program memory and `cpu`.

## Interface
- `PROGRAM_DEPTH`, 1024: number of instruction-memory words; the address width is $clog2(PROGRAM_DEPTH).
- `TENSOR_TIMEOUT`, 255: maximum number of WAIT_TENSOR cycles before a fault is raised.
- `NOP_WORD`, 16'h9000: word driven on the instruction output when nothing is being issued (NOP opcode 4'b1001).
- `clock_in`  in  1  single clock; all state changes on its rising edge.
- `reset_n_in`  in  1  synchronous, active-low reset.
- `start_in`  in  1  pulse; starts execution from address 0 (honoured in IDLE or HALTED only).
- `imem_read_enable_out`  out  1  memory read strobe.
- `imem_address_out`  out  AW  memory read address.
- `imem_data_in`  in  16  read data, valid one cycle after the strobe.
- `tensor_core_done_in`  in  1  `is_tensor_core_done_with_calculation` from `cpu`.
- `current_instruction_out`  out  16  word presented to `cpu`.
- `instruction_valid_out`  out  1  high for exactly one cycle per issued word.
- `program_counter_out`  out  AW  address of the word currently being fetched or issued.
- `busy_out`  out  1  high in FETCH, ISSUE and WAIT_TENSOR.
- `halted_out`  out  1  high in HALTED.
- `fault_out`  out  1  sticky; set by a tensor timeout or by running off the end of memory.
- `issue_count_out`  out  16  number of words issued since the last start; saturates at 16'hFFFF.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT_TENSOR, HALTED.
- Reset values: state IDLE, `current_instruction_out`=NOP_WORD, PC=0, and every other output 0.
- IDLE:
  - `start_in`=1 → FETCH with PC=0, fault cleared, count cleared.
- FETCH:
  - Drive strobe=1 and address=PC.
  - Always advance to ISSUE.
- ISSUE:
  - `imem_data_in` is valid in this cycle.
  - Data == 16'hFFFF → HALTED. The sentinel is not issued, and valid stays 0.
  - Otherwise, at the edge: latch the data into the output register, pulse valid, increment the count, and increment PC.
  - Opcode [15:12]==4'b0101 → WAIT_TENSOR, with the timeout counter cleared.
  - PC == PROGRAM_DEPTH-1 (word just issued was the last address) → HALTED with `fault_out`=1. No wrap-around.
  - Any other case → FETCH.
- WAIT_TENSOR:
  - The first cycle is the issue cycle of the operate word, so done is ignored in that cycle (a stale-high value is discarded).
  - From the second cycle onward, done=1 → FETCH.
  - Each waiting cycle increments the timeout counter. Reaching TENSOR_TIMEOUT with done still low → HALTED with `fault_out`=1.
- HALTED:
  - Holds all outputs.
  - `start_in` restarts exactly as it does from IDLE.
- The output register returns to NOP_WORD in the cycle after every valid pulse.
- `start_in` while busy is ignored.
- Reset low in any state forces reset values at the next edge, including mid-WAIT_TENSOR and mid-ISSUE; the in-flight read is discarded.

## Timing
- Take the start edge as E0 and count cycles after it.
- Word k (non-operate path) is presented in cycle 3+2k: address in cycle 1+2k, data in cycle 2+2k.
- Steady-state throughput: one instruction per 2 cycles.
- Operate instruction: the next FETCH occurs in the cycle after done is first sampled high (earliest: 2 cycles after the operate word's valid cycle).
- Sentinel at address k: `halted_out`=1 from cycle 3+2k; `busy_out` drops in the same cycle.
- `instruction_valid_out` and `current_instruction_out` are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SEQUENCER_SINGLE_STEP_EN` defined:
  - Adds input ports `step_mode_in` and `step_in` (1 bit each).
  - With `step_mode_in`=1, FETCH is entered from the post-issue point only on a `step_in`=1 cycle. This gives exactly one instruction per step; the first fetch after start also waits for a step.
  - `step_in` during a stall is ignored and not queued.
- Macro undefined: the ports do not exist and the sequencer free-runs.

## Test plan
- Reset: hold `reset_n_in` low for 3 cycles → instruction=16'h9000, valid=0, PC=0, busy/halted/fault=0, count=0.
- Basic program: program {16'hA105, 16'h0012, 16'hFFFF}, start → valid with 16'hA105 in cycle 3 and 16'h0012 in cycle 5; halted from cycle 7; count=2; fault=0.
- Tensor stall: program {16'h5000, 16'h0000, 16'hFFFF}, done held at 1 during issue then low for 10 cycles, then high → stale done is ignored; address 1 is fetched only in the cycle after done is sampled high; count=2.
- Timeout: TENSOR_TIMEOUT=8, done never rises → HALTED with fault=1 after 8 wait cycles; a subsequent start clears fault and re-runs from 0.
- Run-off: PROGRAM_DEPTH=4, no sentinel → 4 valid pulses, then halted=1 and fault=1; address never wraps to 0.
- Reset mid-WAIT_TENSOR, and `start_in` pulsed during FETCH → reset returns all outputs to reset values in one edge; the start pulse during FETCH causes no restart (PC continues).
